ps2_rx_fifo: RTL

//  Receives PS/2 keyboard frames from hps_io (ps2_kbd_clk_out/ps2_kbd_data_out) and buffers scancodes.

---
 rtl/ps2_rx_fifo.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo
//   Receives PS/2 keyboard frames (start, 8 data bits LSB first, odd parity,
//   stop) and buffers the resulting scancodes in a first-word-fall-through FIFO.
//   Bad parity, bad stop bit and stalled frames are reported as one-cycle
//   pulses; a good byte lost to a full FIFO sets a sticky overflow flag.
//
// Ports
//   clk_sys     in   system clock, all logic on the rising edge
//   reset       in   synchronous, active-high
//   ps2_clk     in   PS/2 clock (asynchronous; synchronised then filtered)
//   ps2_data    in   PS/2 data (asynchronous; synchronised)
//   rd          in   pop strobe, honoured only while valid=1
//   dout        out  head-of-FIFO scancode, 0 while the FIFO is empty
//   valid       out  FIFO not empty
//   parity_err  out  pulse: frame with bad odd parity was discarded
//   frame_err   out  pulse: frame with stop bit 0 was discarded
//   timeout     out  pulse: in-progress frame aborted after TIMEOUT_CYC idle cycles
//   overflow    out  sticky: a good byte was dropped on a full FIFO
//   dbg_state_o out  receiver FSM state (0 IDLE, 1 DATA, 2 PARITY, 3 STOP)
//
// Handshake: a byte is consumed on every rising edge where rd=1 and valid=1;
// dout/valid reflect the next entry from the following cycle on. rd while
// valid=0 has no effect.

module ps2_rx_fifo #(
  parameter int FILT_LEN    = 4,
  parameter int TIMEOUT_CYC = 50000,
  parameter int DEPTH_LOG2  = 3
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       rd,
  output logic [7:0] dout,
  output logic       valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       timeout,
  output logic       overflow,
  output logic [1:0] dbg_state_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int FCW   = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam int TCW   = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_e;

  // ---------------- synchronisers and clock filter ----------------
  logic           clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  logic           filt_q, filt_d, filt_prev_q;
  logic [FCW-1:0] fcnt_q, fcnt_d;
  logic           fall;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      clk_s1_q    <= 1'b1;
      clk_s2_q    <= 1'b1;
      dat_s1_q    <= 1'b1;
      dat_s2_q    <= 1'b1;
      filt_q      <= 1'b1;
      filt_prev_q <= 1'b1;
      fcnt_q      <= '0;
    end else begin
      clk_s1_q    <= ps2_clk;
      clk_s2_q    <= clk_s1_q;
      dat_s1_q    <= ps2_data;
      dat_s2_q    <= dat_s1_q;
      filt_q      <= filt_d;
      filt_prev_q <= filt_q;
      fcnt_q      <= fcnt_d;
    end
  end

  // A new level must disagree with the filtered clock for FILT_LEN
  // consecutive cycles; any agreement in between restarts the count.
  always_comb begin
    filt_d = filt_q;
    fcnt_d = fcnt_q;
    if (clk_s2_q == filt_q) begin
      fcnt_d = '0;
    end else if (fcnt_q == FCW'(FILT_LEN - 1)) begin
      filt_d = clk_s2_q;
      fcnt_d = '0;
    end else begin
      fcnt_d = fcnt_q + FCW'(1);
    end
  end

  assign fall = filt_prev_q & ~filt_q;

  // ---------------- frame receiver FSM ----------------
  state_e         state_q, state_d;
  logic [7:0]     shreg_q, shreg_d;
  logic [2:0]     bitcnt_q, bitcnt_d;
  logic           par_ok_q, par_ok_d;
  logic [TCW-1:0] tcnt_q, tcnt_d;
  logic           par_err_q, par_err_d, frm_err_q, frm_err_d, tmo_q, tmo_d;
  logic           push;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q   <= S_IDLE;
      shreg_q   <= '0;
      bitcnt_q  <= '0;
      par_ok_q  <= 1'b0;
      tcnt_q    <= '0;
      par_err_q <= 1'b0;
      frm_err_q <= 1'b0;
      tmo_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bitcnt_q  <= bitcnt_d;
      par_ok_q  <= par_ok_d;
      tcnt_q    <= tcnt_d;
      par_err_q <= par_err_d;
      frm_err_q <= frm_err_d;
      tmo_q     <= tmo_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bitcnt_d  = bitcnt_q;
    par_ok_d  = par_ok_q;
    par_err_d = 1'b0;
    frm_err_d = 1'b0;
    tmo_d     = 1'b0;
    push      = 1'b0;
    // Idle counter measures cycles since the last accepted falling edge.
    tcnt_d    = (state_q == S_IDLE || fall) ? '0 : tcnt_q + TCW'(1);

    if (state_q != S_IDLE && !fall && tcnt_q == TCW'(TIMEOUT_CYC - 1)) begin
      state_d = S_IDLE;
      tmo_d   = 1'b1;
      tcnt_d  = '0;
    end else if (fall) begin
      case (state_q)
        S_IDLE: begin
          // A fall with data high is not a start bit; ignore it.
          if (!dat_s2_q) begin
            state_d  = S_DATA;
            bitcnt_d = '0;
          end
        end
        S_DATA: begin
          shreg_d  = {dat_s2_q, shreg_q[7:1]};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) state_d = S_PARITY;
        end
        S_PARITY: begin
          par_ok_d = ^{shreg_q, dat_s2_q};
          state_d  = S_STOP;
        end
        S_STOP: begin
          // A bad stop bit outranks a parity error.
          if (!dat_s2_q)     frm_err_d = 1'b1;
          else if (par_ok_q) push      = 1'b1;
          else               par_err_d = 1'b1;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // ---------------- FWFT FIFO ----------------
  logic [7:0]        mem_q [DEPTH];
  logic [DEPTH_LOG2:0] wptr_q, rptr_q;
  logic              empty, full, pop, wr_en, ovf_q;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[DEPTH_LOG2] != rptr_q[DEPTH_LOG2]) &&
                 (wptr_q[DEPTH_LOG2-1:0] == rptr_q[DEPTH_LOG2-1:0]);
  assign pop   = rd & ~empty;
  // A pop in the same cycle frees the slot the push lands in.
  assign wr_en = push & (~full | pop);

  always_ff @(posedge clk_sys) begin
    if (wr_en) mem_q[wptr_q[DEPTH_LOG2-1:0]] <= shreg_q;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (wr_en) wptr_q <= wptr_q + 1'b1;
      if (pop)   rptr_q <= rptr_q + 1'b1;
      if (push && full && !pop) ovf_q <= 1'b1;
    end
  end

  assign dout        = empty ? 8'h00 : mem_q[rptr_q[DEPTH_LOG2-1:0]];
  assign valid       = ~empty;
  assign parity_err  = par_err_q;
  assign frame_err   = frm_err_q;
  assign timeout     = tmo_q;
  assign overflow    = ovf_q;
  assign dbg_state_o = state_q;

endmodule
